// File: rtl/gpio_lab_1_axil_slave.sv
// AXI4-Lite slave for the lab-1 GPIO block: OUT/TRI/IN/SCRATCH word registers driving the pins.
// Latency: write commits on the edge of the later AW/W handshake; read data is captured at the AR handshake.
// Backpressure: one write and one read in flight; AW/W/AR stall until B/R accepted. Option: GPIO_AXIL_SLVERR_EN.
module gpio_lab_1_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int GPIO_WIDTH         = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [GPIO_WIDTH-1:0]           gpio_i,
    output logic [GPIO_WIDTH-1:0]           gpio_o,
    output logic [GPIO_WIDTH-1:0]           gpio_t
);

    localparam logic [1:0] REG_OUT     = 2'd0;
    localparam logic [1:0] REG_TRI     = 2'd1;
    localparam logic [1:0] REG_IN      = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  ready_en;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [1:0]            aw_sel_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            wr_sel;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           wr_merged;
    logic [1:0]            wr_resp;
    logic [1:0]            bresp_q;
    logic [31:0]           rdata_q;
    logic [31:0]           reg_view [4];
    logic [GPIO_WIDTH-1:0] out_q, tri_q, scratch_q, sync1_q, in_q;

    // Ports and address bits that carry no meaning for this block.
    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_merged};

    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    // Hold the ready outputs low until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) ready_en <= 1'b0;
        else                ready_en <= 1'b1;
    end

    assign S_AXI_AWREADY = ready_en && (w_state == W_IDLE || w_state == W_GOT_W);
    assign S_AXI_WREADY  = ready_en && (w_state == W_IDLE || w_state == W_GOT_AW);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_next;
    end

    // Write FSM next state; commit fires when the second of AW/W lands.
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_GOT_AW;
                end else if (w_hs) begin
                    w_next = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_GOT_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Hold whichever write channel arrived first until its partner shows up.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_sel_q <= 2'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
        end else begin
            if (aw_hs) aw_sel_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // A channel handshaking this cycle is fresher than the held copy.
    assign wr_sel    = aw_hs ? S_AXI_AWADDR[3:2] : aw_sel_q;
    assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign wr_merged = byte_merge(reg_view[wr_sel], wr_data, wr_strb);

`ifdef GPIO_AXIL_SLVERR_EN
    assign wr_resp = (wr_sel == REG_IN) ? 2'b10 : 2'b00;
`else
    assign wr_resp = 2'b00;
`endif

    // Response code is latched with the commit and held through W_RESP.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)  bresp_q <= 2'b00;
        else if (commit)     bresp_q <= wr_resp;
    end

    // Register file; IN is read-only so a write there is dropped.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            out_q     <= '0;
            tri_q     <= '1;
            scratch_q <= '0;
        end else if (commit) begin
            case (wr_sel)
                REG_OUT:     out_q     <= wr_merged[GPIO_WIDTH-1:0];
                REG_TRI:     tri_q     <= wr_merged[GPIO_WIDTH-1:0];
                REG_SCRATCH: scratch_q <= wr_merged[GPIO_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous pin inputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync1_q <= '0;
            in_q    <= '0;
        end else begin
            sync1_q <= gpio_i;
            in_q    <= sync1_q;
        end
    end

    // Zero-extended view of every register, shared by the read and write paths.
    always_comb begin
        reg_view[REG_OUT]     = zext(out_q);
        reg_view[REG_TRI]     = zext(tri_q);
        reg_view[REG_IN]      = zext(in_q);
        reg_view[REG_SCRATCH] = zext(scratch_q);
    end

    assign gpio_o = out_q;
    assign gpio_t = tri_q;

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_next;
    end

    // Read FSM next state: one read in flight, released by RREADY.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Capture read data at the AR handshake so it stays stable under a stalled RREADY;
    // a same-edge write commit is not yet visible, so the pre-write value is returned.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rdata_q <= 32'd0;
        else if (ar_hs)     rdata_q <= reg_view[S_AXI_ARADDR[3:2]];
    end

endmodule

// File: tb/tb_gpio_lab_1_axil_slave.sv
module tb_gpio_lab_1_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;

    int checks   = 0;
    int failures = 0;

`ifdef GPIO_AXIL_SLVERR_EN
    localparam logic [1:0] IN_WR_RESP = 2'b10;
`else
    localparam logic [1:0] IN_WR_RESP = 2'b00;
`endif

    always #5 clk = ~clk;

    gpio_lab_1_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .gpio_i        (gpio_i),
        .gpio_o        (gpio_o),
        .gpio_t        (gpio_t)
    );

    // All driving and sampling happens 1ns after a rising edge.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int cnt;
        logic aw_done, w_done, aw_now, w_now;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_now)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL write_timeout addr=%h bvalid=%b expected 1", addr, bvalid);
            resp = 2'bxx;
        end else begin
            resp = bresp;
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cnt;
        araddr = addr; arvalid = 1'b1; cnt = 0;
        while (!arready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (rvalid !== 1'b1) begin
            failures++;
            $display("FAIL read_timeout addr=%h rvalid=%b expected 1", addr, rvalid);
            data = 32'hx; resp = 2'bxx;
        end else begin
            data = rdata; resp = rresp;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (awready !== 1'b0) begin failures++; $display("FAIL rst_awready got=%b exp=0", awready); end
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL rst_wready got=%b exp=0", wready); end
        checks++; if (arready !== 1'b0) begin failures++; $display("FAIL rst_arready got=%b exp=0", arready); end
        checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL rst_valids got b=%b r=%b exp=0", bvalid, rvalid); end
        checks++; if (bresp !== 2'b00 || rresp !== 2'b00) begin failures++; $display("FAIL rst_resp got b=%b r=%b exp=0", bresp, rresp); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if (gpio_o !== 32'h0) begin failures++; $display("FAIL rst_gpio_o got=%h exp=0", gpio_o); end
        checks++; if (gpio_t !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_gpio_t got=%h exp=ffffffff", gpio_t); end
        rst_n = 1'b1;
        #1;
        checks++; if (awready !== 1'b0) begin failures++; $display("FAIL rel_awready_before_edge got=%b exp=0", awready); end
        @(posedge clk); #1;
        checks++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            failures++; $display("FAIL rel_readys got aw=%b w=%b ar=%b exp=111", awready, wready, arready);
        end
    endtask

    task automatic test_read_stall();
        araddr = 4'h4; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hFFFFFFFF || arready !== 1'b0) begin
                failures++;
                $display("FAIL rd_stall cyc=%0d got rvalid=%b rdata=%h arready=%b exp 1/ffffffff/0", i, rvalid, rdata, arready);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            failures++; $display("FAIL rd_release got rvalid=%b arready=%b exp 0/1", rvalid, arready);
        end
    endtask

    task automatic test_rw();
        logic [3:0]  addrs [3];
        logic [31:0] vals  [3];
        logic [1:0]  resp;
        logic [31:0] rd;
        addrs[0] = 4'h0; vals[0] = 32'h0101FFFF;
        addrs[1] = 4'h4; vals[1] = 32'hABCD0001;
        addrs[2] = 4'hC; vals[2] = 32'hBEEF0011;
        for (int i = 0; i < 3; i++) begin
            do_write(addrs[i], vals[i], 4'hF, resp);
            checks++; if (resp !== 2'b00) begin failures++; $display("FAIL rw_bresp addr=%h got=%b exp=00", addrs[i], resp); end
            if (addrs[i] == 4'h0) begin
                checks++; if (gpio_o !== vals[i]) begin failures++; $display("FAIL rw_gpio_o got=%h exp=%h", gpio_o, vals[i]); end
            end
            if (addrs[i] == 4'h4) begin
                checks++; if (gpio_t !== vals[i]) begin failures++; $display("FAIL rw_gpio_t got=%h exp=%h", gpio_t, vals[i]); end
            end
            do_read(addrs[i], rd, resp);
            checks++; if (rd !== vals[i]) begin failures++; $display("FAIL rw_readback addr=%h got=%h exp=%h", addrs[i], rd, vals[i]); end
            checks++; if (resp !== 2'b00) begin failures++; $display("FAIL rw_rresp addr=%h got=%b exp=00", addrs[i], resp); end
        end
    endtask

    task automatic test_split();
        logic [31:0] rd;
        logic [1:0]  resp;
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        checks++; if (wready !== 1'b1) begin failures++; $display("FAIL split_wready got=%b exp=1", wready); end
        @(posedge clk); #1;
        wvalid = 1'b0;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            failures++; $display("FAIL split_got_w got aw=%b w=%b b=%b exp 1/0/0", awready, wready, bvalid);
        end
        @(posedge clk); #1;
        awaddr = 4'hC; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        checks++; if (bvalid !== 1'b1 || awready !== 1'b0) begin failures++; $display("FAIL split_commit got b=%b aw=%b exp 1/0", bvalid, awready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++; $display("FAIL b_stall cyc=%0d got b=%b aw=%b w=%b exp 1/0/0", i, bvalid, awready, wready);
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin failures++; $display("FAIL b_release got b=%b aw=%b exp 0/1", bvalid, awready); end
        @(posedge clk); #1;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL b_single_pulse got=%b exp=0", bvalid); end
        do_read(4'hC, rd, resp);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL split_readback got=%h exp=11223344", rd); end
        // same-cycle AW and W
        awaddr = 4'h0; wdata = 32'hCAFE0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if (gpio_o !== 32'hCAFE0000 || bvalid !== 1'b1) begin failures++; $display("FAIL same_cycle got gpio_o=%h b=%b exp cafe0000/1", gpio_o, bvalid); end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL same_cycle_bdone got=%b exp=0", bvalid); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic [1:0]  resp;
        do_write(4'h0, 32'hFFFFFFFF, 4'hF, resp);
        do_write(4'h0, 32'h12345678, 4'h5, resp);
        do_read(4'h0, rd, resp);
        checks++; if (rd !== 32'hFF34FF78) begin failures++; $display("FAIL strb5_readback got=%h exp=ff34ff78", rd); end
        checks++; if (gpio_o !== 32'hFF34FF78) begin failures++; $display("FAIL strb5_gpio_o got=%h exp=ff34ff78", gpio_o); end
        do_write(4'h0, 32'h00000000, 4'h0, resp);
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL strb0_bresp got=%b exp=00", resp); end
        do_read(4'h0, rd, resp);
        checks++; if (rd !== 32'hFF34FF78) begin failures++; $display("FAIL strb0_readback got=%h exp=ff34ff78", rd); end
    endtask

    task automatic test_in();
        logic [31:0] rd;
        logic [1:0]  resp;
        gpio_i = 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        #1;
        do_read(4'h8, rd, resp);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL in_read got=%h exp=a5a5a5a5", rd); end
        // pin change and AR in the same cycle: synchronizer delay hides the new value
        gpio_i = 32'h5A5A5A5A; araddr = 4'h8; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        checks++; if (rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL in_sync_delay got=%h exp=a5a5a5a5", rdata); end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        do_read(4'h8, rd, resp);
        checks++; if (rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL in_read_new got=%h exp=5a5a5a5a", rd); end
        do_write(4'h8, 32'hDEAD0011, 4'hF, resp);
        checks++; if (resp !== IN_WR_RESP) begin failures++; $display("FAIL in_write_bresp got=%b exp=%b", resp, IN_WR_RESP); end
        do_read(4'h8, rd, resp);
        checks++; if (rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL in_write_ignored got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [1:0]  resp;
        // write commit and read handshake to SCRATCH on the same edge
        awaddr = 4'hC; wdata = 32'h99887766; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11223344 || bvalid !== 1'b1) begin
            failures++; $display("FAIL same_edge_rw got r=%b rdata=%h b=%b exp 1/11223344/1", rvalid, rdata, bvalid);
        end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(4'hC, rd, resp);
        checks++; if (rd !== 32'h99887766) begin failures++; $display("FAIL same_edge_after got=%h exp=99887766", rd); end
        do_write(4'h4, 32'h0000F0F0, 4'hF, resp);
        do_write(4'h4, 32'h00000F0F, 4'hF, resp);
        checks++; if (gpio_t !== 32'h00000F0F) begin failures++; $display("FAIL b2b_gpio_t got=%h exp=00000f0f", gpio_t); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  resp;
        awaddr = 4'h0; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if (bvalid !== 1'b1 || gpio_o !== 32'h77) begin failures++; $display("FAIL mid_pending got b=%b gpio_o=%h exp 1/00000077", bvalid, gpio_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL mid_bvalid got=%b exp=0", bvalid); end
        checks++; if (gpio_o !== 32'h0 || gpio_t !== 32'hFFFFFFFF) begin failures++; $display("FAIL mid_regs got o=%h t=%h exp 0/ffffffff", gpio_o, gpio_t); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL mid_no_resp got=%b exp=0", bvalid); end
        do_read(4'h0, rd, resp);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_out got=%h exp=0", rd); end
        do_read(4'h4, rd, resp);
        checks++; if (rd !== 32'hFFFFFFFF) begin failures++; $display("FAIL mid_tri got=%h exp=ffffffff", rd); end
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        gpio_i = '0;
        test_reset();
        test_read_stall();
        test_rw();
        test_split();
        test_strobe();
        test_in();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
